// File: rtl/aes_keyexp_nlane.sv
// aes_keyexp_nlane
// Computes the next AES key-schedule quartet {w8..w11} from a sliding word
// window, for AES-128 or AES-256 steps selected per request. SubWord goes
// through an external, shared S-box, SBOX_LANES bytes at a time.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake (in_ready high only when idle)
//   key256                  0 = AES-128 step, 1 = AES-256 step
//   win_in[255:0]           {w0..w7}, w0 in [255:224]
//   rcon_idx_in, use_rcon_in  Rcon index and AES-256 step phase
//   out_valid / out_ready   result handshake, result held until accepted
//   q_out[127:0]            {w8,w9,w10,w11}, w8 in [127:96]
//   rcon_idx_out, use_rcon_out  next-step Rcon index and phase
//   sbox_en                 high while the S-box port is owned
//   sbox_in / sbox_out      S-box request bytes / results, lane k = [8k+7:8k]
module aes_keyexp_nlane #(
    parameter int SBOX_LANES  = 1,
    parameter bit SUPPORT_256 = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    key256,
    input  logic [255:0]            win_in,
    input  logic [3:0]              rcon_idx_in,
    input  logic                    use_rcon_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            q_out,
    output logic [3:0]              rcon_idx_out,
    output logic                    use_rcon_out,
    output logic                    sbox_en,
    output logic [8*SBOX_LANES-1:0] sbox_in,
    input  logic [8*SBOX_LANES-1:0] sbox_out
);

    generate
        if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
            $error("aes_keyexp_nlane: SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam int LW = 8 * SBOX_LANES;
    // Number of issue/capture rounds needed to cover the 4 source bytes.
    localparam int G = (SBOX_LANES == 1) ? 4 : (SBOX_LANES == 2) ? 2 : 1;
    localparam logic [1:0] LAST = 2'(G - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [127:0]   win_q, win_d;       // w0..w3, all the recurrence needs
    logic [31:0]    src_q, src_d;       // remaining source bytes, next group on top
    logic [31:0]    acc_q, acc_d;       // SubWord accumulator
    logic [1:0]     cnt_q, cnt_d;
    logic           mode_q, mode_d;
    logic [3:0]     idx_q, idx_d;
    logic           use_q, use_d;
    logic [127:0]   res_q, res_d;
    logic [3:0]     ridx_q, ridx_d;
    logic           ruse_q, ruse_d;

    logic           mode_in;
    logic [31:0]    src_word;
    logic [31+LW:0] acc_shift;
    logic [31:0]    sub_word;
    logic [7:0]     rc_byte;
    logic [31:0]    t_word, w8, w9, w10, w11;
    logic           unused_bits;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // With SUPPORT_256=0 the mode is constant 0 and the AES-256 paths fold away.
    assign mode_in  = SUPPORT_256 && key256;
    assign src_word = !mode_in       ? rot_word(win_in[159:128]) :
                      use_rcon_in    ? rot_word(win_in[31:0])    : win_in[31:0];

    // Appending the newest group at the bottom keeps the first-issued byte on top.
    assign acc_shift = {acc_q, sbox_out};
    assign sub_word  = acc_shift[31:0];

    assign rc_byte = (mode_q && !use_q) ? 8'h00 : rcon(idx_q);
    assign t_word  = sub_word ^ {rc_byte, 24'h0};
    assign w8      = win_q[127:96] ^ t_word;
    assign w9      = win_q[95:64]  ^ w8;
    assign w10     = win_q[63:32]  ^ w9;
    assign w11     = win_q[31:0]   ^ w10;

    assign unused_bits = ^{win_in[127:32], acc_shift[31+LW:32]};

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        src_d   = src_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        use_d   = use_q;
        res_d   = res_q;
        ridx_d  = ridx_q;
        ruse_d  = ruse_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    win_d   = win_in[255:128];
                    src_d   = src_word;
                    mode_d  = mode_in;
                    idx_d   = rcon_idx_in;
                    use_d   = use_rcon_in;
                    cnt_d   = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                acc_d = sub_word;
                if (cnt_q == LAST) begin
                    res_d   = {w8, w9, w10, w11};
                    ridx_d  = mode_q ? idx_q + {3'b000, use_q} : idx_q + 4'd1;
                    ruse_d  = mode_q ? ~use_q : 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    src_d   = src_q << LW;
                    state_d = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            src_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            use_q   <= 1'b1;
            res_q   <= '0;
            ridx_q  <= '0;
            ruse_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            src_q   <= src_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            use_q   <= use_d;
            res_q   <= res_d;
            ridx_q  <= ridx_d;
            ruse_q  <= ruse_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_HOLD);
    assign sbox_en      = (state_q == S_ISSUE) || (state_q == S_CAPTURE);
    // sbox_in is the top group of a register, so it only changes on a clock edge.
    assign sbox_in      = src_q[31 -: LW];
    assign q_out        = res_q;
    assign rcon_idx_out = ridx_q;
    assign use_rcon_out = ruse_q;

endmodule

// File: tb/tb_aes_keyexp_nlane.sv
// Bench for aes_keyexp_nlane: three instances (1, 2 and 4 S-box lanes) share
// the request stream; each has its own registered S-box model and its own
// read pointer into the shared expected-result queue.
module tb_aes_keyexp_nlane;

    localparam logic [2047:0] SBOX_PK = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] KEY128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] JUNK   = 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978;
    localparam logic [255:0] KEY256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    typedef struct packed {
        logic [127:0] q;
        logic [3:0]   idx;
        logic         use_r;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, key256, use_rcon_in, out_ready;
    logic [255:0] win_in;
    logic [3:0]   rcon_idx_in;

    logic         in_ready_w [3];
    logic         out_valid_w [3];
    logic         use_out_w [3];
    logic         sbox_en_w [3];
    logic [127:0] q_w [3];
    logic [3:0]   idx_w [3];
    logic [31:0]  sbin_w [3];

    logic [7:0]   sbox_tbl [256];
    logic [127:0] rk [11];
    exp_t         exp_q [$];

    int checks = 0;
    int errors = 0;
    int lat [3];
    int en [3];
    int rd [3] = '{0, 0, 0};
    int exp_lat [3] = '{8, 4, 2};
    bit pend [3] = '{0, 0, 0};
    bit hold_prev [3] = '{0, 0, 0};
    logic [127:0] q_prev [3];

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) sbox_tbl[i] = SBOX_PK[2047-8*i -: 8];
    end

    genvar gk;
    generate
        for (gk = 0; gk < 3; gk++) begin : g_dut
            localparam int L = (gk == 0) ? 1 : (gk == 1) ? 2 : 4;
            logic [8*L-1:0] si;
            logic [8*L-1:0] so;
            aes_keyexp_nlane #(.SBOX_LANES(L), .SUPPORT_256(1'b1)) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .in_valid     (in_valid),
                .in_ready     (in_ready_w[gk]),
                .key256       (key256),
                .win_in       (win_in),
                .rcon_idx_in  (rcon_idx_in),
                .use_rcon_in  (use_rcon_in),
                .out_valid    (out_valid_w[gk]),
                .out_ready    (out_ready),
                .q_out        (q_w[gk]),
                .rcon_idx_out (idx_w[gk]),
                .use_rcon_out (use_out_w[gk]),
                .sbox_en      (sbox_en_w[gk]),
                .sbox_in      (si),
                .sbox_out     (so)
            );
            assign sbin_w[gk] = 32'(si);
            // Registered S-box: result appears the cycle after sbox_in changes.
            always @(posedge clk) begin
                for (int b = 0; b < L; b++) so[8*b +: 8] <= sbox_tbl[si[8*b +: 8]];
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: latency / S-box ownership, hold stability, scoreboard compare.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                pend[k]      = 1'b0;
                hold_prev[k] = 1'b0;
            end else begin
                if (pend[k]) begin
                    lat[k]++;
                    if (sbox_en_w[k]) en[k]++;
                    if (out_valid_w[k]) begin
                        chk($sformatf("latency_L%0d", 1 << k), 128'(lat[k]), 128'(exp_lat[k] + 1));
                        chk($sformatf("sbox_en_cycles_L%0d", 1 << k), 128'(en[k]), 128'(exp_lat[k]));
                        pend[k] = 1'b0;
                    end else if (lat[k] > 100) begin
                        chk($sformatf("latency_timeout_L%0d", 1 << k), 128'(lat[k]), 128'(exp_lat[k] + 1));
                        pend[k] = 1'b0;
                    end
                end
                if (out_valid_w[k]) begin
                    chk($sformatf("hold_in_ready_L%0d", 1 << k), 128'(in_ready_w[k]), 128'(0));
                    if (hold_prev[k])
                        chk($sformatf("hold_q_stable_L%0d", 1 << k), q_w[k], q_prev[k]);
                    if (out_ready) begin
                        if (rd[k] < exp_q.size()) begin
                            chk($sformatf("q_out_L%0d_n%0d", 1 << k, rd[k]), q_w[k], exp_q[rd[k]].q);
                            chk($sformatf("rcon_idx_out_L%0d_n%0d", 1 << k, rd[k]), 128'(idx_w[k]), 128'(exp_q[rd[k]].idx));
                            chk($sformatf("use_rcon_out_L%0d_n%0d", 1 << k, rd[k]), 128'(use_out_w[k]), 128'(exp_q[rd[k]].use_r));
                            rd[k]++;
                        end else begin
                            chk($sformatf("output_count_L%0d", 1 << k), 128'(rd[k] + 1), 128'(exp_q.size()));
                        end
                    end
                end
                hold_prev[k] = out_valid_w[k] && !out_ready;
                q_prev[k]    = q_w[k];
                if (in_valid && in_ready_w[k]) begin
                    pend[k] = 1'b1;
                    lat[k]  = 0;
                    en[k]   = 0;
                end
            end
        end
    end

    function automatic bit all_idle();
        return in_ready_w[0] && in_ready_w[1] && in_ready_w[2] &&
               !out_valid_w[0] && !out_valid_w[1] && !out_valid_w[2];
    endfunction

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (all_idle()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 128'({in_ready_w[0], in_ready_w[1], in_ready_w[2]}), 128'(3'b111));
    endtask

    task automatic send(input logic k256, input logic [255:0] win, input logic [3:0] idx,
                        input logic use_r, input bit push, input logic [127:0] eq,
                        input logic [3:0] eidx, input logic euse);
        exp_t e;
        if (push) begin
            e.q = eq; e.idx = eidx; e.use_r = euse;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; key256 = k256; win_in = win; rcon_idx_in = idx; use_rcon_in = use_r;
        @(posedge clk); #1;
        // Scramble everything after the accept edge; the DUT must not care.
        in_valid = 1'b0; key256 = ~k256; win_in = ~win; rcon_idx_in = ~idx; use_rcon_in = ~use_r;
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_in_ready_L%0d", tag, 1 << k), 128'(in_ready_w[k]), 128'(1));
            chk($sformatf("%s_out_valid_L%0d", tag, 1 << k), 128'(out_valid_w[k]), 128'(0));
            chk($sformatf("%s_q_out_L%0d", tag, 1 << k), q_w[k], 128'(0));
            chk($sformatf("%s_rcon_idx_L%0d", tag, 1 << k), 128'(idx_w[k]), 128'(0));
            chk($sformatf("%s_use_rcon_L%0d", tag, 1 << k), 128'(use_out_w[k]), 128'(1));
            chk($sformatf("%s_sbox_en_L%0d", tag, 1 << k), 128'(sbox_en_w[k]), 128'(0));
            chk($sformatf("%s_sbox_in_L%0d", tag, 1 << k), 128'(sbin_w[k]), 128'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual %0t required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rk[0]  = KEY128;
        rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; key256 = 1'b0;
        use_rcon_in = 1'b0; rcon_idx_in = 4'd0; win_in = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle();

        // T1: AES-128 first round key.
        send(1'b0, {KEY128, JUNK}, 4'd0, 1'b1, 1'b1, rk[1], 4'd1, 1'b1);
        wait_idle();

        // T2: AES-256, Rcon step then the plain SubWord step on the slid window.
        send(1'b1, KEY256, 4'd0, 1'b1, 1'b1,
             128'h9ba35411_8e6925af_a51a8b5f_2067fcde, 4'd1, 1'b0);
        wait_idle();
        send(1'b1, {KEY256[127:0], 128'h9ba35411_8e6925af_a51a8b5f_2067fcde}, 4'd1, 1'b0, 1'b1,
             128'ha8b09c1a_93d194cd_be49846e_b75d5b9a, 4'd1, 1'b1);
        wait_idle();

        // T3: full AES-128 chain; use_rcon toggles but must be ignored in AES-128.
        for (int i = 0; i < 10; i++) begin
            send(1'b0, {rk[i], JUNK}, 4'(i), 1'(i), 1'b1, rk[i+1], 4'(i + 1), 1'b1);
            wait_idle();
        end

        // Rcon index past the table gives RC=00: only bit 24 of every word differs from T1.
        send(1'b0, {KEY128, JUNK}, 4'd10, 1'b1, 1'b1,
             128'ha1fafe17_89542cb1_22a33939_2b6c7605, 4'd11, 1'b1);
        wait_idle();
        send(1'b0, {KEY128, JUNK}, 4'd15, 1'b0, 1'b1,
             128'ha1fafe17_89542cb1_22a33939_2b6c7605, 4'd0, 1'b1);
        wait_idle();

        // T5: consumer stalls; a new request during HOLD must be ignored.
        out_ready = 1'b0;
        send(1'b0, {KEY128, JUNK}, 4'd0, 1'b1, 1'b1, rk[1], 4'd1, 1'b1);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid_w[0] && out_valid_w[1] && out_valid_w[2]) break;
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; key256 = 1'b0; win_in = {rk[5], JUNK}; rcon_idx_in = 4'd3;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // T6: reset mid-CAPTURE discards the quartet, then a clean restart.
        send(1'b0, {KEY128, JUNK}, 4'd0, 1'b1, 1'b0, '0, 4'd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_reset("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle();
        send(1'b0, {KEY128, JUNK}, 4'd0, 1'b1, 1'b1, rk[1], 4'd1, 1'b1);
        wait_idle();
        repeat (5) @(negedge clk);

        for (int k = 0; k < 3; k++)
            chk($sformatf("drained_L%0d", 1 << k), 128'(rd[k]), 128'(exp_q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
